// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative write-back/write-allocate data cache, 1-bit LRU per set.
// Define DCACHE_STATS_EN to add hit_cnt_o/miss_cnt_o counters.
module dcache_2way_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int OFF_W = $clog2(LINE_W / 8);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int WSEL_W = OFF_W - 2;

    typedef enum logic [2:0] {
        IDLE, MISS, WRITEBACK, REFILL, REFILLOK
    } state_e;

    state_e state_q, state_d;

    logic [TAG_W-1:0]  tag_q   [2][SETS];
    logic [LINE_W-1:0] data_q  [2][SETS];
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   valid_d [2];
    logic [SETS-1:0]   dirty_q [2];
    logic [SETS-1:0]   dirty_d [2];
    logic [SETS-1:0]   lru_q, lru_d;

    logic              vway_q, vway_d;
    logic [IDX_W-1:0]  vidx_q, vidx_d;
    logic [TAG_W-1:0]  mtag_q, mtag_d;

    logic [TAG_W-1:0]  p_tag;
    logic [IDX_W-1:0]  p_idx;
    logic [WSEL_W-1:0] p_word;
    logic              req, hit0, hit1, hit, hit_way, idle;
    logic              victim, vdirty, fill_en, whit_en;
    logic [LINE_W-1:0] hit_line;
    logic [ADDR_W-1:0] wb_addr, rf_addr;
    logic              unused_addr;

    assign p_tag  = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign p_idx  = p1_addr_i[OFF_W +: IDX_W];
    assign p_word = p1_addr_i[2 +: WSEL_W];
    assign unused_addr = ^p1_addr_i[1:0];

    assign req  = p1_MemRead_i | p1_MemWrite_i;
    assign hit0 = req & valid_q[0][p_idx] & (tag_q[0][p_idx] == p_tag);
    assign hit1 = req & valid_q[1][p_idx] & (tag_q[1][p_idx] == p_tag);
    assign hit  = hit0 | hit1;
    assign hit_way = hit1;
    assign idle = (state_q == IDLE);

    // Prefer an empty way; fall back to the LRU way of the set.
    assign victim = ~valid_q[0][p_idx] ? 1'b0 :
                    ~valid_q[1][p_idx] ? 1'b1 : lru_q[p_idx];
    assign vdirty = valid_q[vway_q][vidx_q] & dirty_q[vway_q][vidx_q];

    assign fill_en = (state_q == REFILL) & mem_ack_i;
    assign whit_en = idle & p1_MemWrite_i & hit;

    assign wb_addr = {tag_q[vway_q][vidx_q], vidx_q, {OFF_W{1'b0}}};
    assign rf_addr = {mtag_q, vidx_q, {OFF_W{1'b0}}};

    always_comb begin
        hit_line  = hit_way ? data_q[1][p_idx] : data_q[0][p_idx];
        p1_data_o = '0;
        if (p1_MemRead_i & hit) begin
            p1_data_o = hit_line[{p_word, 5'd0} +: 32];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (req & ~hit) state_d = MISS;
            MISS:      state_d = vdirty ? WRITEBACK : REFILL;
            WRITEBACK: if (mem_ack_i) state_d = REFILL;
            REFILL:    if (mem_ack_i) state_d = REFILLOK;
            REFILLOK:  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Memory request is raised already in MISS so the address is set up early.
    always_comb begin
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = rf_addr;
        unique case (state_q)
            MISS: begin
                mem_enable_o = 1'b1;
                mem_write_o  = vdirty;
                mem_addr_o   = vdirty ? wb_addr : rf_addr;
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = wb_addr;
            end
            REFILL: begin
                mem_enable_o = 1'b1;
            end
            default: ;
        endcase
        p1_stall_o = req & ~(hit & idle);
    end

    assign mem_data_o = data_q[vway_q][vidx_q];

    always_comb begin
        vway_d  = vway_q;
        vidx_d  = vidx_q;
        mtag_d  = mtag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        lru_d   = lru_q;
        if (idle & req & ~hit) begin
            vway_d = victim;
            vidx_d = p_idx;
            mtag_d = p_tag;
        end
        if (fill_en) begin
            valid_d[vway_q][vidx_q] = 1'b1;
            dirty_d[vway_q][vidx_q] = 1'b0;
            lru_d[vidx_q] = ~vway_q;
        end else if (idle & hit) begin
            lru_d[p_idx] = ~hit_way;
        end
        if (whit_en) begin
            dirty_d[hit_way][p_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
            lru_q   <= '0;
            vway_q  <= 1'b0;
            vidx_q  <= '0;
            mtag_q  <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            lru_q   <= lru_d;
            vway_q  <= vway_d;
            vidx_q  <= vidx_d;
            mtag_q  <= mtag_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            data_q[vway_q][vidx_q] <= mem_data_i;
            tag_q[vway_q][vidx_q]  <= mtag_q;
        end else if (whit_en) begin
            data_q[hit_way][p_idx][{p_word, 5'd0} +: 32] <= p1_data_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q + 32'(idle & hit);
        miss_cnt_d = miss_cnt_q + 32'(idle & req & ~hit);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Directed bench for dcache_2way_ctrl with a latency-programmable line memory.
// Memory line default content: word at byte address a reads as a ^ 32'hA5000000.
module tb_dcache_2way_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  p1_addr, p1_wdata, p1_rdata;
    logic         p1_rd, p1_wr, p1_stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_data_o, mem_data_i;
    logic         mem_enable, mem_write, mem_ack;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_cnt, miss_cnt;
`endif

    int checks = 0;
    int failures = 0;

    dcache_2way_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
`ifdef DCACHE_STATS_EN
        .hit_cnt_o     (hit_cnt),
        .miss_cnt_o    (miss_cnt),
`endif
        .p1_addr_i     (p1_addr),
        .p1_data_i     (p1_wdata),
        .p1_MemRead_i  (p1_rd),
        .p1_MemWrite_i (p1_wr),
        .p1_data_o     (p1_rdata),
        .p1_stall_o    (p1_stall),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_data_o),
        .mem_enable_o  (mem_enable),
        .mem_write_o   (mem_write),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [31:0] la);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i*32 +: 32] = 32'hA500_0000 ^ (la + 32'(i * 4));
        end
        return r;
    endfunction

    // Line memory: ack raised for one cycle once enable has been seen lat+1 times.
    logic [255:0] mem [logic [31:0]];
    int           lat = 10;
    int           mem_cnt = 0;
    int           rd_n = 0;
    int           wb_n = 0;
    logic [31:0]  wb_addr = '0;
    logic [255:0] wb_data = '0;
    logic [255:0] wb_first = '0;
    logic         wb_track = 1'b0;
    logic         wb_unstable = 1'b0;

    initial begin
        mem_ack = 1'b0;
        mem_data_i = '0;
    end

    always @(negedge clk) begin
        if (mem_enable && mem_write) begin
            if (!wb_track) begin
                wb_track = 1'b1;
                wb_first = mem_data_o;
            end else if (mem_data_o !== wb_first) begin
                wb_unstable = 1'b1;
            end
        end else begin
            wb_track = 1'b0;
        end
        if (mem_ack) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else if (mem_enable) begin
            if (mem_cnt == lat) begin
                mem_ack = 1'b1;
                mem_cnt = 0;
                if (mem_write) begin
                    mem[mem_addr] = mem_data_o;
                    wb_n++;
                    wb_addr = mem_addr;
                    wb_data = mem_data_o;
                end else begin
                    mem_data_i = mem.exists(mem_addr) ? mem[mem_addr] : pat(mem_addr);
                    rd_n++;
                end
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    int exp_hits = 0;
    int exp_miss = 0;

    // Called at posedge+1; returns at posedge+1 with the request dropped.
    task automatic access(input logic [31:0] a, input logic wr,
                          input logic [31:0] wd, output int stalls,
                          output logic [31:0] rdata);
        logic done;
        p1_addr  = a;
        p1_wdata = wd;
        p1_rd    = ~wr;
        p1_wr    = wr;
        stalls   = 0;
        rdata    = '0;
        done     = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!p1_stall) begin
                rdata = p1_rdata;
                done  = 1'b1;
            end else begin
                stalls++;
                if (stalls > 200) begin
                    check("timeout", 256'(stalls), 256'd200);
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        exp_hits++;
        if (stalls > 0) exp_miss++;
    endtask

    task automatic ld(input string tag, input logic [31:0] a,
                      input logic [31:0] exp_d, input int exp_s);
        int s;
        logic [31:0] d;
        access(a, 1'b0, '0, s, d);
        check({tag, "_data"}, d, exp_d);
        check({tag, "_stall"}, s, exp_s);
    endtask

    initial begin
        int s;
        int rd0, wb0;
        logic [31:0] d;
        logic [255:0] mod_line;

        rst = 1'b1;
        p1_addr = '0;
        p1_wdata = '0;
        p1_rd = 1'b0;
        p1_wr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_en", mem_enable, 0);
        check("rst_wr", mem_write, 0);
        check("rst_stall", p1_stall, 0);
        check("rst_data", p1_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_en", mem_enable, 0);
        @(posedge clk);
        #1;

        // Cold miss: enable rises in MISS, ack 10 cycles later -> 13 stalls.
        ld("c1_cold", 32'h40, 32'hA500_0040, 13);
        check("c1_rd_n", rd_n, 1);
        check("c1_wb_n", wb_n, 0);
        ld("c1_reload", 32'h40, 32'hA500_0040, 0);

        access(32'h44, 1'b1, 32'hDEAD_BEEF, s, d);
        check("c2_st_stall", s, 0);
        check("c2_st_data", d, 0);
        ld("c2_ld44", 32'h44, 32'hDEAD_BEEF, 0);
        for (int i = 0; i < 8; i++) begin
            if (i != 1) begin
                ld($sformatf("c2_w%0d", i), 32'h40 + 32'(4 * i),
                   32'hA500_0040 ^ 32'(4 * i), 0);
            end
        end

        wb0 = wb_n;
        ld("c3_440", 32'h440, 32'hA500_0440, 13);
        ld("c3_040a", 32'h40, 32'hA500_0040, 0);
        ld("c3_840", 32'h840, 32'hA500_0840, 13);
        check("c3_no_wb", wb_n, wb0);
        ld("c3_040b", 32'h40, 32'hA500_0040, 0);
        ld("c3_440_gone", 32'h440, 32'hA500_0440, 13);

        // Dirty way0 (0x40) is LRU: write-back then refill.
        mod_line = pat(32'h40);
        mod_line[63:32] = 32'hDEAD_BEEF;
        wb0 = wb_n;
        rd0 = rd_n;
        wb_unstable = 1'b0;
        ld("c4_C40", 32'hC40, 32'hA500_0C40, 25);
        check("c4_wb_n", wb_n, wb0 + 1);
        check("c4_rd_n", rd_n, rd0 + 1);
        check("c4_wb_addr", wb_addr, 32'h40);
        check("c4_wb_data", wb_data, mod_line);
        check("c4_wb_stable", wb_unstable, 0);
        ld("c4_044_mem", 32'h44, 32'hDEAD_BEEF, 13);

`ifdef DCACHE_STATS_EN
        check("st_hits", hit_cnt, exp_hits);
        check("st_miss", miss_cnt, exp_miss);
`endif

        // Reset during REFILL of 0x1040.
        p1_addr = 32'h1040;
        p1_rd = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("c5_in_refill", {mem_enable, mem_write}, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        p1_rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("c5_en", mem_enable, 0);
        check("c5_wr", mem_write, 0);
        check("c5_stall", p1_stall, 0);
        check("c5_data", p1_rdata, 0);
`ifdef DCACHE_STATS_EN
        check("c5_st_hits", hit_cnt, 0);
        check("c5_st_miss", miss_cnt, 0);
`endif
        @(posedge clk);
        #1;
        ld("c5_040", 32'h40, 32'hA500_0040, 13);
        ld("c5_C40", 32'hC40, 32'hA500_0C40, 13);
        ld("c5_044", 32'h44, 32'hDEAD_BEEF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
